// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the simple-CPU sequencer.
//   state_t     : controller FSM states
//   instr_t     : decoded instruction class
//   OP_* / AO_* : opcode and ALU_op field values
//   RM/RD/RN    : reg_sel encodings
//   WB_*        : wb_sel encodings
//   decode_instr: maps {opcode, ALU_op} to an instruction class
package seq_ctrl_pkg;

    typedef enum logic [3:0] {
        S_WAIT, S_DEC, S_WRI, S_LA, S_LB, S_LC, S_WR, S_ST,
        S_AC, S_AD, S_MEM, S_WRM, S_LBD, S_SC
    } state_t;

    typedef enum logic [3:0] {
        I_ILL, I_MOVI, I_MOV, I_ADD, I_CMP, I_AND, I_MVN, I_LDR, I_STR
    } instr_t;

    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;
    localparam logic [2:0] OP_LDR = 3'b011;
    localparam logic [2:0] OP_STR = 3'b100;

    localparam logic [1:0] AO_MOVI = 2'b10;
    localparam logic [1:0] AO_MOV  = 2'b00;
    localparam logic [1:0] AO_ADD  = 2'b00;
    localparam logic [1:0] AO_CMP  = 2'b01;
    localparam logic [1:0] AO_AND  = 2'b10;
    localparam logic [1:0] AO_MVN  = 2'b11;
    localparam logic [1:0] AO_MEM  = 2'b00;

    localparam logic [1:0] RM = 2'b00;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] RN = 2'b10;

    localparam logic [1:0] WB_C   = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;

    function automatic instr_t decode_instr(input logic [2:0] opcode,
                                            input logic [1:0] alu_op);
        instr_t cls;
        cls = I_ILL;
        case (opcode)
            OP_MOV: begin
                if (alu_op == AO_MOVI)     cls = I_MOVI;
                else if (alu_op == AO_MOV) cls = I_MOV;
            end
            OP_ALU: begin
                case (alu_op)
                    AO_ADD:  cls = I_ADD;
                    AO_CMP:  cls = I_CMP;
                    AO_AND:  cls = I_AND;
                    default: cls = I_MVN;
                endcase
            end
            OP_LDR: if (alu_op == AO_MEM) cls = I_LDR;
            OP_STR: if (alu_op == AO_MEM) cls = I_STR;
            default: cls = I_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles spent in the MEM state.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : hold count at zero (asserted whenever the FSM is outside MEM)
//   en         : count this cycle (asserted in MEM)
//   expired    : high during the MEM_TIMEOUT-th counted cycle
module mem_timeout_ctr
    import seq_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    // cnt holds (MEM cycle number - 1); it saturates at LAST because the
    // FSM always leaves MEM on the cycle expired is seen.
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle controller for the simple-CPU datapath.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : begin instruction (sampled in WAIT only)
//   opcode, ALU_op       : instruction fields, latched when start is accepted
//   shift_op, Z, N, V    : passed through / reserved, not decoded here
//   mem_ack              : single-cycle memory completion
//   waiting              : high in WAIT
//   reg_sel, wb_sel      : register file read / write-back selects
//   w_en, en_A, en_B, en_C, en_status, en_addr : datapath load enables
//   sel_A, sel_B         : operand overrides (A=0, B=sximm5)
//   mem_req, mem_we      : memory request and write qualifier
//   err                  : sticky illegal-instruction / memory-timeout flag
module seq_controller
    import seq_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 16,
    parameter bit STATUS_ON_ALL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [1:0] ALU_op,
    input  logic [1:0] shift_op,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    input  logic       mem_ack,
    output logic       waiting,
    output logic [1:0] reg_sel,
    output logic [1:0] wb_sel,
    output logic       w_en,
    output logic       en_A,
    output logic       en_B,
    output logic       en_C,
    output logic       en_status,
    output logic       sel_A,
    output logic       sel_B,
    output logic       en_addr,
    output logic       mem_req,
    output logic       mem_we,
    output logic       err
);

    state_t state, next_state;
    instr_t instr;
    logic   accept;
    logic   err_set;
    logic   expired;

    // Shift field and status flags are not used by the sequencing.
    logic unused_inputs;
    assign unused_inputs = ^{shift_op, Z, N, V};

    assign accept = (state == S_WAIT) && start;

    mem_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != S_MEM),
        .en      (state == S_MEM),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
            instr <= I_ILL;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                instr <= decode_instr(opcode, ALU_op);
                err   <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        err_set    = 1'b0;
        waiting    = 1'b0;
        reg_sel    = RM;
        wb_sel     = WB_C;
        w_en       = 1'b0;
        en_A       = 1'b0;
        en_B       = 1'b0;
        en_C       = 1'b0;
        en_status  = 1'b0;
        sel_A      = 1'b0;
        sel_B      = 1'b0;
        en_addr    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;

        case (state)
            S_WAIT: begin
                waiting = 1'b1;
                if (start) next_state = S_DEC;
            end
            S_DEC: begin
                case (instr)
                    I_MOVI:                      next_state = S_WRI;
                    I_MOV, I_MVN:                next_state = S_LB;
                    I_ADD, I_AND, I_CMP,
                    I_LDR, I_STR:                next_state = S_LA;
                    default: begin
                        next_state = S_WAIT;
                        err_set    = 1'b1;
                    end
                endcase
            end
            S_WRI: begin
                reg_sel    = RN;
                wb_sel     = WB_IMM;
                w_en       = 1'b1;
                next_state = S_WAIT;
            end
            S_LA: begin
                reg_sel    = RN;
                en_A       = 1'b1;
                next_state = (instr == I_LDR || instr == I_STR) ? S_AC : S_LB;
            end
            S_LB: begin
                reg_sel    = RM;
                en_B       = 1'b1;
                next_state = (instr == I_CMP) ? S_ST : S_LC;
            end
            S_LC: begin
                en_C       = 1'b1;
                en_status  = STATUS_ON_ALL &&
                             (instr == I_ADD || instr == I_AND || instr == I_MVN);
                next_state = S_WR;
            end
            S_WR: begin
                reg_sel    = RD;
                wb_sel     = WB_C;
                w_en       = 1'b1;
                next_state = S_WAIT;
            end
            S_ST: begin
                en_status  = 1'b1;
                next_state = S_WAIT;
            end
            S_AC: begin
                sel_B      = 1'b1;
                en_C       = 1'b1;
                next_state = S_AD;
            end
            S_AD: begin
                en_addr    = 1'b1;
                next_state = (instr == I_STR) ? S_LBD : S_MEM;
            end
            S_LBD: begin
                reg_sel    = RD;
                en_B       = 1'b1;
                next_state = S_SC;
            end
            S_SC: begin
                sel_A      = 1'b1;
                en_C       = 1'b1;
                next_state = S_MEM;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (instr == I_STR);
                // An ack on the last allowed cycle still completes normally.
                if (mem_ack) begin
                    next_state = (instr == I_LDR) ? S_WRM : S_WAIT;
                end else if (expired) begin
                    next_state = S_WAIT;
                    err_set    = 1'b1;
                end
            end
            S_WRM: begin
                reg_sel    = RD;
                wb_sel     = WB_MEM;
                w_en       = 1'b1;
                next_state = S_WAIT;
            end
            default: next_state = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_seq_controller.sv
module tb_seq_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] opcode;
    logic [1:0] ALU_op;
    logic [1:0] shift_op;
    logic       Z, N, V;
    logic       mem_ack;
    logic       waiting;
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en, en_A, en_B, en_C, en_status;
    logic       sel_A, sel_B, en_addr, mem_req, mem_we, err;

    int checks = 0;
    int errors = 0;

    seq_controller #(.MEM_TIMEOUT(4), .STATUS_ON_ALL(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .ALU_op    (ALU_op),
        .shift_op  (shift_op),
        .Z         (Z),
        .N         (N),
        .V         (V),
        .mem_ack   (mem_ack),
        .waiting   (waiting),
        .reg_sel   (reg_sel),
        .wb_sel    (wb_sel),
        .w_en      (w_en),
        .en_A      (en_A),
        .en_B      (en_B),
        .en_C      (en_C),
        .en_status (en_status),
        .sel_A     (sel_A),
        .sel_B     (sel_B),
        .en_addr   (en_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .err       (err)
    );

    always #5 clk = ~clk;

    // {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
    //  sel_A, sel_B, en_addr, mem_req, mem_we}
    logic [14:0] outs;
    assign outs = {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
                   sel_A, sel_B, en_addr, mem_req, mem_we};

    localparam logic [14:0] O_WAIT  = 15'h4000;
    localparam logic [14:0] O_DEC   = 15'h0000;
    localparam logic [14:0] O_WRI   = 15'h2A00;
    localparam logic [14:0] O_LA    = 15'h2100;
    localparam logic [14:0] O_LB    = 15'h0080;
    localparam logic [14:0] O_LC    = 15'h0040;
    localparam logic [14:0] O_WR    = 15'h1200;
    localparam logic [14:0] O_ST    = 15'h0020;
    localparam logic [14:0] O_AC    = 15'h0048;
    localparam logic [14:0] O_AD    = 15'h0004;
    localparam logic [14:0] O_MEML  = 15'h0002;
    localparam logic [14:0] O_MEMS  = 15'h0003;
    localparam logic [14:0] O_WRM   = 15'h1600;
    localparam logic [14:0] O_LBD   = 15'h1080;
    localparam logic [14:0] O_SC    = 15'h0050;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Check outputs in the current cycle, then move to the next negedge.
    task automatic cyc(input string tag, input logic [14:0] exp);
        chk(tag, {1'b0, outs}, {1'b0, exp});
        @(negedge clk);
    endtask

    // Drive start for one cycle; returns at the negedge of the DEC cycle.
    task automatic issue(input logic [2:0] op, input logic [1:0] ao);
        opcode = op;
        ALU_op = ao;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        opcode   = 3'b000;
        ALU_op   = 2'b00;
        shift_op = 2'b00;
        Z = 1'b0; N = 1'b0; V = 1'b0;
        mem_ack  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs", {1'b0, outs}, {1'b0, O_WAIT});
        chk("rst_err", {15'd0, err}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD: DEC LA LB LC WR (no en_status in LC)
        issue(3'b101, 2'b00);
        cyc("add_dec", O_DEC);
        cyc("add_la", O_LA);
        cyc("add_lb", O_LB);
        cyc("add_lc", O_LC);
        cyc("add_wr", O_WR);
        cyc("add_wait", O_WAIT);

        // CMP: DEC LA LB ST, status only in ST
        issue(3'b101, 2'b01);
        cyc("cmp_dec", O_DEC);
        cyc("cmp_la", O_LA);
        cyc("cmp_lb", O_LB);
        cyc("cmp_st", O_ST);
        cyc("cmp_wait", O_WAIT);

        // MVN: DEC LB LC WR
        issue(3'b101, 2'b11);
        cyc("mvn_dec", O_DEC);
        cyc("mvn_lb", O_LB);
        cyc("mvn_lc", O_LC);
        cyc("mvn_wr", O_WR);
        cyc("mvn_wait", O_WAIT);

        // Reset mid-ADD while in LB: outputs return immediately
        issue(3'b101, 2'b00);
        cyc("rst_add_dec", O_DEC);
        cyc("rst_add_la", O_LA);
        chk("rst_add_lb", {1'b0, outs}, {1'b0, O_LB});
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outs", {1'b0, outs}, {1'b0, O_WAIT});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'b110, 2'b10);
        cyc("movi_dec", O_DEC);
        cyc("movi_wri", O_WRI);
        cyc("movi_wait", O_WAIT);

        // LDR, ack in 3rd MEM cycle: 8 cycles to waiting
        issue(3'b011, 2'b00);
        cyc("ldr_dec", O_DEC);
        cyc("ldr_la", O_LA);
        cyc("ldr_ac", O_AC);
        cyc("ldr_ad", O_AD);
        cyc("ldr_mem1", O_MEML);
        cyc("ldr_mem2", O_MEML);
        mem_ack = 1'b1;
        cyc("ldr_mem3", O_MEML);
        mem_ack = 1'b0;
        cyc("ldr_wrm", O_WRM);
        cyc("ldr_wait", O_WAIT);
        chk("ldr_err", {15'd0, err}, 16'd0);

        // STR with no ack: 4 MEM cycles then WAIT with err
        issue(3'b100, 2'b00);
        cyc("strto_dec", O_DEC);
        cyc("strto_la", O_LA);
        cyc("strto_ac", O_AC);
        cyc("strto_ad", O_AD);
        cyc("strto_lbd", O_LBD);
        cyc("strto_sc", O_SC);
        cyc("strto_mem1", O_MEMS);
        cyc("strto_mem2", O_MEMS);
        cyc("strto_mem3", O_MEMS);
        cyc("strto_mem4", O_MEMS);
        chk("strto_err", {15'd0, err}, 16'd1);
        cyc("strto_wait", O_WAIT);
        // ack outside MEM is ignored
        mem_ack = 1'b1;
        cyc("ack_idle", O_WAIT);
        mem_ack = 1'b0;
        chk("err_sticky", {15'd0, err}, 16'd1);

        // MOV clears err; start during the sequence is ignored
        issue(3'b110, 2'b00);
        chk("err_clr", {15'd0, err}, 16'd0);
        cyc("mov_dec", O_DEC);
        opcode = 3'b110; ALU_op = 2'b10; start = 1'b1;
        cyc("mov_lb", O_LB);
        start = 1'b0;
        cyc("mov_lc", O_LC);
        cyc("mov_wr", O_WR);
        cyc("mov_wait", O_WAIT);
        cyc("mov_wait2", O_WAIT);

        // STR with ack in MEM cycle 4 (= timeout): normal completion
        issue(3'b100, 2'b00);
        cyc("str_dec", O_DEC);
        cyc("str_la", O_LA);
        cyc("str_ac", O_AC);
        cyc("str_ad", O_AD);
        cyc("str_lbd", O_LBD);
        cyc("str_sc", O_SC);
        cyc("str_mem1", O_MEMS);
        cyc("str_mem2", O_MEMS);
        cyc("str_mem3", O_MEMS);
        mem_ack = 1'b1;
        cyc("str_mem4", O_MEMS);
        mem_ack = 1'b0;
        cyc("str_wait", O_WAIT);
        chk("str_err", {15'd0, err}, 16'd0);

        // Illegal 111_00: DEC then WAIT with err
        issue(3'b111, 2'b00);
        cyc("ill_dec", O_DEC);
        cyc("ill_wait", O_WAIT);
        chk("ill_err", {15'd0, err}, 16'd1);

        // Illegal 110_01 also flagged
        issue(3'b110, 2'b01);
        chk("ill2_clr", {15'd0, err}, 16'd0);
        cyc("ill2_dec", O_DEC);
        cyc("ill2_wait", O_WAIT);
        chk("ill2_err", {15'd0, err}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
